serial_receiver: RTL
====================

SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame, LSB first.
REQ-002 SHALL have parameter OVERSAMPLE, default 8, OversampleTick pulses per bit period; even, >=4.
REQ-003 SHALL have port Clock, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port ResetN, input, 1, synchronous active-low reset.
REQ-005 SHALL have port OversampleTick, input, 1, one-Clock pulse at OVERSAMPLE x baud from the baud-rate generator.
REQ-006 SHALL have port Rx, input, 1, asynchronous serial line, idle high.
REQ-007 SHALL have port RxData, output, DATA_BITS, received byte holding register.
REQ-008 SHALL have port RxValid, output, 1, RxData holds an unconsumed byte.
REQ-009 SHALL have port RxReady, input, 1, consumer accepts RxData when RxValid&&RxReady.
REQ-010 SHALL have port FramingError, output, 1, one-Clock pulse when the stop bit samples low.
REQ-011 SHALL have port ParityError, output, 1, one-Clock pulse on parity mismatch.
REQ-012 SHALL have port Overrun, output, 1, sticky: a frame was dropped because the holding register was full.
REQ-013 SHALL have port Busy, output, 1, high in every state except IDLE.

Function
REQ-014 Rx SHALL pass through a 2-flop synchronizer; both flops reset to 1; all decisions use the synchronized value.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_IDLE; counters and FSM SHALL advance only on cycles with OversampleTick=1.
REQ-016 IDLE: on a tick with synced Rx=0 -> START, tick counter=0.
REQ-017 START: on tick count OVERSAMPLE/2-1 (mid-bit), sample; 1 -> IDLE (glitch, no output); 0 -> DATA, counter=0, bit index=0.
REQ-018 DATA: sample on every OVERSAMPLE-th tick, shift into the data register LSB first; after DATA_BITS samples -> PARITY if compiled in, else STOP.
REQ-019 STOP: sample after OVERSAMPLE ticks; 1 with no parity error -> deliver frame, return to IDLE; 0 -> FramingError pulse, frame discarded, go to WAIT_IDLE.
REQ-020 WAIT_IDLE: remain until a tick sees synced Rx=1, then go to IDLE; this prevents a break condition from retriggering START.
REQ-021 Delivery: if RxValid=0, or RxValid&&RxReady in the same cycle, load RxData and set RxValid=1 in the cycle after the stop sample.
REQ-022 Delivery with RxValid=1 and RxReady=0: keep the old RxData, drop the new frame, set Overrun=1.
REQ-023 A handshake (RxValid&&RxReady) with no simultaneous delivery SHALL clear RxValid the next cycle; RxData holds its value.
REQ-024 Overrun SHALL clear only on the next successful handshake; a handshake coincident with the overrun-setting cycle cannot occur, because REQ-021 applies.
REQ-025 Latency: RxValid rises exactly 1 Clock after the tick that samples the stop bit.

Reset
REQ-026 With ResetN=0 at a rising Clock edge: FSM->IDLE, counters=0, RxData=0, RxValid=0, FramingError=0, ParityError=0, Overrun=0, Busy=0, synchronizer=1.
REQ-027 Reset mid-frame SHALL abandon the frame with no output pulse; reception resumes with the next falling edge after ResetN=1.

Configuration
REQ-028 Macro SERIAL_RX_PARITY_EN defined: the PARITY state samples one even-parity bit after DATA after OVERSAMPLE ticks, then -> STOP; on mismatch, pulse ParityError in the stop-sample cycle and discard the frame.
REQ-029 Macro SERIAL_RX_PARITY_EN undefined: no PARITY state exists and ParityError is tied to 0.

Structure
REQ-030 Shared package serial_pkg SHALL hold the rx state enum, DEFAULT_OVERSAMPLE=8 and DEFAULT_DATA_BITS=8.
REQ-031 Sub-module serial_sync SHALL implement the 2-flop synchronizer with reset value 1.
REQ-032 Target size: 120-400 lines of RTL.

Verification
REQ-033 Frame 0xA5 (8N1, 8 ticks/bit), RxReady=1 -> RxValid pulse with RxData=0xA5, no error flags.
REQ-034 Rx low for 2 ticks, then high -> state returns to IDLE, RxValid stays 0, Busy falls after the mid-start sample.
REQ-035 Two frames 0x11 then 0x22 with RxReady=0 -> RxData=0x11, Overrun=1; raising RxReady clears Overrun and RxValid.
REQ-036 Frame 0x3C with stop bit 0, then Rx held low for 30 ticks -> one FramingError pulse, no RxValid, stays in WAIT_IDLE until Rx=1.
REQ-037 ResetN=0 asserted during bit 4 of a frame -> all outputs 0; a following clean frame 0x5A is received correctly.
REQ-038 With SERIAL_RX_PARITY_EN defined, frame 0x07 with parity 0 (wrong) -> ParityError pulse, no RxValid; with parity 1 -> RxData=0x07.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial receiver: receive FSM states and default geometry.
// The parity state only exists when SERIAL_RX_PARITY_EN is defined.
package serial_pkg;

   localparam int unsigned DEFAULT_OVERSAMPLE = 8;
   localparam int unsigned DEFAULT_DATA_BITS  = 8;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StStart    = 3'd1,
      StData     = 3'd2,
`ifdef SERIAL_RX_PARITY_EN
      StParity   = 3'd3,
`endif
      StStop     = 3'd4,
      StWaitIdle = 3'd5
   } rx_state_e;

endpackage

// File: rtl/serial_sync.sv
// Two-flop synchronizer for the asynchronous serial line; both flops reset to the idle level.
module serial_sync (
   input  logic clock,
   input  logic reset_n,
   input  logic async_in,
   output logic sync_out
);

   logic meta;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         meta     <= 1'b1;
         sync_out <= 1'b1;
      end else begin
         meta     <= async_in;
         sync_out <= meta;
      end
   end

endmodule

// File: rtl/serial_receiver.sv
// Oversampling UART receiver with a one-entry holding register and valid/ready handoff.
// Optional even-parity checking is compiled in with SERIAL_RX_PARITY_EN.
module serial_receiver
   import serial_pkg::*;
#(
   parameter int unsigned DATA_BITS  = DEFAULT_DATA_BITS,
   parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
   input  logic                 Clock,
   input  logic                 ResetN,
   input  logic                 OversampleTick,
   input  logic                 Rx,
   output logic [DATA_BITS-1:0] RxData,
   output logic                 RxValid,
   input  logic                 RxReady,
   output logic                 FramingError,
   output logic                 ParityError,
   output logic                 Overrun,
   output logic                 Busy
);

   localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
   localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

   rx_state_e            state;
   logic [CNT_W-1:0]     tick_cnt;
   logic [IDX_W-1:0]     bit_idx;
   logic [DATA_BITS-1:0] shift;
   logic                 rx_sync;
   logic                 handshake;
   logic                 frame_bad;

   serial_sync u_sync (
      .clock    (Clock),
      .reset_n  (ResetN),
      .async_in (Rx),
      .sync_out (rx_sync)
   );

   assign handshake = RxValid && RxReady;
   assign Busy      = (state != StIdle);

`ifdef SERIAL_RX_PARITY_EN
   logic par_bad;
   assign frame_bad = par_bad;
`else
   assign frame_bad   = 1'b0;
   assign ParityError = 1'b0;
`endif

   always_ff @(posedge Clock) begin
      if (!ResetN) begin
         state        <= StIdle;
         tick_cnt     <= '0;
         bit_idx      <= '0;
         shift        <= '0;
         RxData       <= '0;
         RxValid      <= 1'b0;
         FramingError <= 1'b0;
         Overrun      <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
         par_bad      <= 1'b0;
         ParityError  <= 1'b0;
`endif
      end else begin
         FramingError <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
         ParityError  <= 1'b0;
`endif
         // A delivery later in this block overrides the handshake clear of RxValid.
         if (handshake) begin
            RxValid <= 1'b0;
            Overrun <= 1'b0;
         end
         if (OversampleTick) begin
            unique case (state)
               StIdle: begin
                  if (!rx_sync) begin
                     state    <= StStart;
                     tick_cnt <= '0;
                  end
               end
               StStart: begin
                  if (tick_cnt == HALF_LAST) begin
                     tick_cnt <= '0;
                     bit_idx  <= '0;
                     state    <= rx_sync ? StIdle : StData;
                  end else begin
                     tick_cnt <= tick_cnt + CNT_W'(1);
                  end
               end
               StData: begin
                  if (tick_cnt == BIT_LAST) begin
                     tick_cnt <= '0;
                     shift    <= {rx_sync, shift[DATA_BITS-1:1]};
                     if (bit_idx == IDX_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
                        state <= StParity;
`else
                        state <= StStop;
`endif
                     end else begin
                        bit_idx <= bit_idx + IDX_W'(1);
                     end
                  end else begin
                     tick_cnt <= tick_cnt + CNT_W'(1);
                  end
               end
`ifdef SERIAL_RX_PARITY_EN
               StParity: begin
                  if (tick_cnt == BIT_LAST) begin
                     tick_cnt <= '0;
                     par_bad  <= (rx_sync != ^shift);
                     state    <= StStop;
                  end else begin
                     tick_cnt <= tick_cnt + CNT_W'(1);
                  end
               end
`endif
               StStop: begin
                  if (tick_cnt == BIT_LAST) begin
                     tick_cnt <= '0;
`ifdef SERIAL_RX_PARITY_EN
                     ParityError <= par_bad;
`endif
                     if (!rx_sync) begin
                        FramingError <= 1'b1;
                        state        <= StWaitIdle;
                     end else begin
                        state <= StIdle;
                        if (!frame_bad) begin
                           if (!RxValid || RxReady) begin
                              RxData  <= shift;
                              RxValid <= 1'b1;
                           end else begin
                              Overrun <= 1'b1;
                           end
                        end
                     end
                  end else begin
                     tick_cnt <= tick_cnt + CNT_W'(1);
                  end
               end
               // Hold off a line break so it cannot retrigger a start bit.
               StWaitIdle: begin
                  if (rx_sync) begin
                     state <= StIdle;
                  end
               end
               default: state <= StIdle;
            endcase
         end
      end
   end

endmodule
